// File: rtl/apb_if.sv
// APB bus bundle between the bridge's APB controller (master) and one responder (slave).
interface apb_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB responder backed by a 16 x 32-bit register file; reg 15 is a read-only ID.
// Programmable wait states via pready, bad accesses flagged on pslverr.
module apb_slave_regfile #(
  parameter int unsigned WAIT_STATES   = 0,
  parameter logic [31:0] ID_VALUE      = 32'hA5B0_0001,
  parameter bit          ADDR_HI_CHECK = 1'b1
) (
  input logic  hclk,
  input logic  hresetn,
  apb_if.slave apb
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [3:0]  idx_r;
  logic        write_r;
  logic [31:0] wdata_r;
  logic        err_r;
  logic [31:0] regs_r [16];

  logic        pready_s;
  logic [31:0] rdata_s;
  logic        err_s;

  // Misaligned, out-of-window, or a write to the read-only ID register.
  function automatic logic addr_err(input logic [31:0] addr, input logic wr);
    logic hi_bad;
    hi_bad = ADDR_HI_CHECK && (addr[31:6] != 26'd0);
    return (addr[1:0] != 2'b00) || hi_bad || (wr && (addr[5:2] == 4'hF));
  endfunction

  // Error decision for the transfer presented in the setup phase.
  always_comb begin
    err_s = addr_err(apb.paddr, apb.pwrite);
  end

  // Transfer FSM, wait counter, setup latches and register file.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= 4'd0;
      write_r <= 1'b0;
      wdata_r <= 32'd0;
      err_r   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (apb.psel && !apb.penable) begin
            idx_r   <= apb.paddr[5:2];
            write_r <= apb.pwrite;
            wdata_r <= apb.pwdata;
            err_r   <= err_s;
            cnt_r   <= 4'(WAIT_STATES);
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (!(apb.psel && apb.penable)) begin
            // Master dropped the transfer: discard it without touching the registers.
            state_r <= IDLE;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            if (write_r && !err_r) begin
              regs_r[idx_r] <= wdata_r;
            end
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Completion strobe and read data, qualified by the live access-phase handshake.
  always_comb begin
    pready_s = (state_r == ACCESS) && (cnt_r == 4'd0) && apb.psel && apb.penable;
    rdata_s  = 32'd0;
    if (pready_s && !write_r && !err_r) begin
      if (idx_r == 4'hF) begin
        rdata_s = ID_VALUE;
      end else begin
        rdata_s = regs_r[idx_r];
      end
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign apb.pready  = pready_s;
  assign apb.prdata  = rdata_s;
  assign apb.pslverr = pready_s & err_r;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Drives two responders (0 and 3 wait states) from one shared APB bus with a two-bit psel,
// checking directed vectors, abort/reset corner cases and random traffic against a reference model.
module tb_apb_slave_regfile;
  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        hclk_s    = 1'b0;
  logic        hresetn_s = 1'b0;
  logic [1:0]  psel_s    = 2'b00;
  logic        penable_s = 1'b0;
  logic        pwrite_s  = 1'b0;
  logic [31:0] paddr_s   = 32'd0;
  logic [31:0] pwdata_s  = 32'd0;

  int errors_s = 0;
  int checks_s = 0;
  logic [31:0] model_mem [2][16];

  apb_if if0 ();
  apb_if if3 ();

  assign if0.psel    = psel_s[0];
  assign if3.psel    = psel_s[1];
  assign if0.penable = penable_s;
  assign if3.penable = penable_s;
  assign if0.pwrite  = pwrite_s;
  assign if3.pwrite  = pwrite_s;
  assign if0.paddr   = paddr_s;
  assign if3.paddr   = paddr_s;
  assign if0.pwdata  = pwdata_s;
  assign if3.pwdata  = pwdata_s;

  apb_slave_regfile #(.WAIT_STATES(0)) dut0 (.hclk(hclk_s), .hresetn(hresetn_s), .apb(if0.slave));
  apb_slave_regfile #(.WAIT_STATES(3)) dut3 (.hclk(hclk_s), .hresetn(hresetn_s), .apb(if3.slave));

  always #5 hclk_s = ~hclk_s;

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_s++;
    if (act !== exp) begin
      errors_s++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic mon_pready(input int d);
    return (d != 0) ? if3.pready : if0.pready;
  endfunction

  function automatic logic mon_err(input int d);
    return (d != 0) ? if3.pslverr : if0.pslverr;
  endfunction

  function automatic logic [31:0] mon_rdata(input int d);
    return (d != 0) ? if3.prdata : if0.prdata;
  endfunction

  // One setup + access transfer; address/data are scrambled during wait states.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int cyc);
    bit done;
    @(negedge hclk_s);
    psel_s    = (d != 0) ? 2'b10 : 2'b01;
    penable_s = 1'b0;
    pwrite_s  = wr;
    paddr_s   = addr;
    pwdata_s  = wdata;
    @(negedge hclk_s);
    penable_s = 1'b1;
    cyc   = 0;
    rdata = 32'd0;
    err   = 1'b0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      cyc++;
      if (mon_pready(d)) begin
        rdata = mon_rdata(d);
        err   = mon_err(d);
        done  = 1'b1;
      end else begin
        @(negedge hclk_s);
        paddr_s  = $urandom;
        pwdata_s = $urandom;
      end
    end
    if (!done) cyc = -1;
  endtask

  task automatic bus_idle();
    @(negedge hclk_s);
    psel_s    = 2'b00;
    penable_s = 1'b0;
  endtask

  // Expected response straight from the address map rules; commits writes into the model.
  task automatic run_checked(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input string tag);
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          cyc;
    int          idx;
    idx    = int'(addr[5:2]);
    exp_er = (addr[1:0] != 2'b00) || (addr[31:6] != 26'd0) || (wr && idx == 15);
    if (wr || exp_er) exp_rd = 32'd0;
    else if (idx == 15) exp_rd = ID;
    else exp_rd = model_mem[d][idx];
    xfer(d, wr, addr, wdata, rd, er, cyc);
    check({tag, " cycles"}, 32'(cyc), (d != 0) ? 32'd4 : 32'd1);
    check({tag, " pslverr"}, {31'd0, er}, {31'd0, exp_er});
    check({tag, " prdata"}, rd, exp_rd);
    if (wr && !exp_er) model_mem[d][idx] = wdata;
  endtask

  initial begin
    vec_t        vecs [13];
    logic [31:0] rd;
    logic        er;
    int          cyc;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) model_mem[d][i] = 32'd0;

    vecs[0]  = '{0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,          1'b0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF,  1'b0};
    vecs[2]  = '{1, 1'b0, 32'h0000_003C, 32'h0,         ID,             1'b0};
    vecs[3]  = '{1, 1'b1, 32'h0000_003C, 32'h1234,      32'h0,          1'b1};
    vecs[4]  = '{1, 1'b0, 32'h0000_003C, 32'h0,         ID,             1'b0};
    vecs[5]  = '{0, 1'b0, 32'h0000_0042, 32'h0,         32'h0,          1'b1};
    vecs[6]  = '{0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,          1'b1};
    vecs[7]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h0,          1'b0};
    vecs[8]  = '{0, 1'b0, 32'h0000_003C, 32'h0,         ID,             1'b0};
    vecs[9]  = '{1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0,          1'b0};
    vecs[10] = '{1, 1'b0, 32'h0000_0020, 32'h0,         32'h0BAD_F00D,  1'b0};
    vecs[11] = '{0, 1'b0, 32'h0000_0020, 32'h0,         32'h0,          1'b0};
    vecs[12] = '{0, 1'b0, 32'h8000_0000, 32'h0,         32'h0,          1'b1};

    // Reset state.
    repeat (2) @(negedge hclk_s);
    #1;
    check("reset pready0",  {31'd0, if0.pready},  32'd0);
    check("reset pslverr0", {31'd0, if0.pslverr}, 32'd0);
    check("reset prdata0",  if0.prdata,           32'd0);
    check("reset pready3",  {31'd0, if3.pready},  32'd0);
    @(negedge hclk_s);
    hresetn_s = 1'b1;

    // Directed vectors, issued back to back.
    for (int i = 0; i < 13; i++) begin
      xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, cyc);
      check($sformatf("vec%0d cycles", i), 32'(cyc), (vecs[i].d != 0) ? 32'd4 : 32'd1);
      check($sformatf("vec%0d pslverr", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rdata);
      if (vecs[i].wr && !vecs[i].exp_err) model_mem[vecs[i].d][int'(vecs[i].addr[5:2])] = vecs[i].wdata;
    end
    bus_idle();

    // Abort: penable dropped during the wait states of a write to reg 1.
    @(negedge hclk_s);
    psel_s = 2'b10; penable_s = 1'b0; pwrite_s = 1'b1; paddr_s = 32'h04; pwdata_s = 32'h55;
    @(negedge hclk_s);
    penable_s = 1'b1;
    #1 check("abort wait1 pready", {31'd0, if3.pready}, 32'd0);
    @(negedge hclk_s);
    #1 check("abort wait2 pready", {31'd0, if3.pready}, 32'd0);
    @(negedge hclk_s);
    penable_s = 1'b0;
    #1 check("abort drop pready", {31'd0, if3.pready}, 32'd0);
    @(negedge hclk_s);
    psel_s = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk_s);
      #1 check($sformatf("abort idle%0d pready", i), {31'd0, if3.pready}, 32'd0);
    end
    run_checked(1, 1'b0, 32'h04, 32'h0, "abort readback");
    run_checked(1, 1'b1, 32'h04, 32'h77, "post-abort write");
    run_checked(1, 1'b0, 32'h04, 32'h0, "post-abort read");

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      int          d, r;
      logic        wr;
      logic [31:0] addr;
      d    = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      r    = int'($urandom_range(0, 9));
      if (r == 0) addr[1:0] = 2'($urandom_range(1, 3));
      else if (r == 1) addr[$urandom_range(6, 31)] = 1'b1;
      run_checked(d, wr, addr, $urandom, $sformatf("rand%0d", n));
    end
    bus_idle();

    // Reset asserted while a write to reg 4 is presenting pready.
    @(negedge hclk_s);
    psel_s = 2'b01; penable_s = 1'b0; pwrite_s = 1'b1; paddr_s = 32'h10; pwdata_s = 32'hFFFF_FFFF;
    @(negedge hclk_s);
    penable_s = 1'b1;
    #1 check("rst pre pready", {31'd0, if0.pready}, 32'd1);
    hresetn_s = 1'b0;
    #1;
    check("rst pready",  {31'd0, if0.pready},  32'd0);
    check("rst pslverr", {31'd0, if0.pslverr}, 32'd0);
    check("rst prdata",  if0.prdata,           32'd0);
    psel_s = 2'b00; penable_s = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) model_mem[d][i] = 32'd0;
    @(negedge hclk_s);
    hresetn_s = 1'b1;
    run_checked(0, 1'b0, 32'h10, 32'h0, "rst reg4");
    run_checked(0, 1'b0, 32'h08, 32'h0, "rst reg2");
    run_checked(1, 1'b0, 32'h20, 32'h0, "rst reg8 dut3");
    bus_idle();

    $display("Result: errors=%0d of %0d checks", errors_s, checks_s);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
